serial_to_parallel: RTL and testbench

Deserialiser between the FPGA-side serial link and the MRAM/async-SRAM parallel interface. Three serial lanes (address, data, control) are sampled one bit per clock, LSB first, while ctrl_en is high. Each completed frame is presented as a 20-bit address, a 16-bit data word and five active-low memory strobes. The outputs drive the MRAM pins directly.

---
 rtl/s2p_pkg.sv | 20 ++
 rtl/s2p_lane.sv | 40 ++++
 rtl/serial_to_parallel.sv | 102 ++++++++++
 tb/tb_serial_to_parallel.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/s2p_pkg.sv
// rtl/s2p_pkg.sv - shared widths, strobe indices and idle value for the serial-to-parallel deserialiser
package s2p_pkg;

  // Frame length in clocks equals the address width.
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int CTRL_W = 5;
  localparam int CNT_W  = $clog2(ADDR_W);

  // Position of each memory strobe inside the control lane.
  localparam int CE_IDX = 0;
  localparam int WE_IDX = 1;
  localparam int OE_IDX = 2;
  localparam int LB_IDX = 3;
  localparam int UB_IDX = 4;

  // All strobes are active-low, so all-ones deselects the memory.
  localparam logic [CTRL_W-1:0] STROBE_IDLE = 5'b11111;

endpackage

// File: rtl/s2p_lane.sv
// rtl/s2p_lane.sv - one serial lane: bit-indexed capture register with enable and async clear
// Ports:
//   clk, rst   clock; asynchronous active-low clear of the capture register
//   en         capture enable (bit at idx is written on the rising edge)
//   idx        frame bit position; positions at or above WIDTH are ignored
//   bit_in     serial bit for position idx
//   cap        registered captured bits
//   cap_next   cap with the current bit merged in, used to load a frame on its last edge
module s2p_lane #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  input  logic             bit_in,
  output logic [WIDTH-1:0] cap,
  output logic [WIDTH-1:0] cap_next
);

  // Loop compare avoids indexing cap with an index wider than the lane.
  always_comb begin
    cap_next = cap;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx == IDX_W'(i)) begin
        cap_next[i] = bit_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap <= '0;
    end else if (en) begin
      cap <= cap_next;
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// rtl/serial_to_parallel.sv - three-lane serial deserialiser driving MRAM/async-SRAM parallel pins
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   ctrl_en         frame enable, high while serial bits are valid
//   addr_in         serial address bit, LSB first
//   data_in         serial data bit, LSB first
//   ctrl            serial control bit, LSB first
//   addr_out        registered parallel address
//   data_out        registered parallel write data
//   chip_en .. upper_byte_en   active-low memory strobes, control bits 0..4
module serial_to_parallel
  import s2p_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_en,
  input  logic              addr_in,
  input  logic              data_in,
  input  logic              ctrl,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              chip_en,
  output logic              write_en,
  output logic              out_en,
  output logic              lower_byte_en,
  output logic              upper_byte_en
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADDR_W - 1);

  logic [CNT_W-1:0]  cnt;
  logic              frame_done;
  logic [ADDR_W-1:0] addr_cap, addr_next;
  logic [DATA_W-1:0] data_cap, data_next;
  logic [CTRL_W-1:0] ctrl_cap, ctrl_next;
  logic [CTRL_W-1:0] strobe_q;

  assign frame_done = ctrl_en && (cnt == CNT_LAST);

  s2p_lane #(.WIDTH(ADDR_W), .IDX_W(CNT_W)) u_addr_lane (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl_en),
    .idx      (cnt),
    .bit_in   (addr_in),
    .cap      (addr_cap),
    .cap_next (addr_next)
  );

  s2p_lane #(.WIDTH(DATA_W), .IDX_W(CNT_W)) u_data_lane (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl_en),
    .idx      (cnt),
    .bit_in   (data_in),
    .cap      (data_cap),
    .cap_next (data_next)
  );

  s2p_lane #(.WIDTH(CTRL_W), .IDX_W(CNT_W)) u_ctrl_lane (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl_en),
    .idx      (cnt),
    .bit_in   (ctrl),
    .cap      (ctrl_cap),
    .cap_next (ctrl_next)
  );

  // Outputs load from the merged "next" values so the last bit lands on the
  // same edge that samples it; cnt wraps for back-to-back frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      addr_out <= '0;
      data_out <= '0;
      strobe_q <= STROBE_IDLE;
    end else begin
      if (!ctrl_en || cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (frame_done) begin
        addr_out <= addr_next;
        data_out <= data_next;
        strobe_q <= ctrl_next;
      end
    end
  end

  assign chip_en       = strobe_q[CE_IDX];
  assign write_en      = strobe_q[WE_IDX];
  assign out_en        = strobe_q[OE_IDX];
  assign lower_byte_en = strobe_q[LB_IDX];
  assign upper_byte_en = strobe_q[UB_IDX];

  // Captured bits feed the outputs only through the *_next merge paths.
  logic unused_cap;
  assign unused_cap = ^{addr_cap, data_cap, ctrl_cap};

endmodule

// File: tb/tb_serial_to_parallel.sv
// tb/tb_serial_to_parallel.sv - directed self-checking bench for serial_to_parallel
module tb_serial_to_parallel;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ctrl_en = 1'b0;
  logic        addr_in = 1'b0;
  logic        data_in = 1'b0;
  logic        ctrl = 1'b0;
  logic [19:0] addr_out;
  logic [15:0] data_out;
  logic        chip_en, write_en, out_en, lower_byte_en, upper_byte_en;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [19:0] exp_addr;
  logic [15:0] exp_data;
  logic [4:0]  exp_strb;

  always #5 clk = ~clk;

  serial_to_parallel dut (
    .clk           (clk),
    .rst           (rst),
    .ctrl_en       (ctrl_en),
    .addr_in       (addr_in),
    .data_in       (data_in),
    .ctrl          (ctrl),
    .addr_out      (addr_out),
    .data_out      (data_out),
    .chip_en       (chip_en),
    .write_en      (write_en),
    .out_en        (out_en),
    .lower_byte_en (lower_byte_en),
    .upper_byte_en (upper_byte_en)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".addr"}, 32'(addr_out), 32'(exp_addr));
    check({tag, ".data"}, 32'(data_out), 32'(exp_data));
    check({tag, ".strb"}, 32'({upper_byte_en, lower_byte_en, out_en, write_en, chip_en}), 32'(exp_strb));
  endtask

  // Drive frame bits [first, first+n) on the falling edge; bits above a
  // lane's width are driven to 1 so that ignoring them is exercised.
  task automatic drive_bits(input logic [19:0] a, input logic [15:0] d, input logic [4:0] c,
                            input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      @(negedge clk);
      ctrl_en = 1'b1;
      addr_in = a[i];
      data_in = (i < 16) ? d[i] : 1'b1;
      ctrl    = (i < 5) ? c[i] : 1'b1;
      @(posedge clk);
    end
  endtask

  // Full frame: outputs must hold through edge 19 and change on edge 20.
  task automatic send_frame(input string tag, input logic [19:0] a, input logic [15:0] d,
                            input logic [4:0] c);
    drive_bits(a, d, c, 0, 19);
    #1 check_outputs({tag, ".pre"});
    drive_bits(a, d, c, 19, 1);
    exp_addr = a;
    exp_data = d;
    exp_strb = c;
    #1 check_outputs({tag, ".post"});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ctrl_en = 1'b0;
      addr_in = 1'b1;
      data_in = 1'b1;
      ctrl    = 1'b0;
    end
  endtask

  initial begin
    exp_addr = 20'h00000;
    exp_data = 16'h0000;
    exp_strb = 5'b11111;

    // Reset with arbitrary inputs toggling.
    rst = 1'b0; ctrl_en = 1'b1; addr_in = 1'b1; data_in = 1'b1; ctrl = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    idle(20);
    @(posedge clk);
    #1 check_outputs("idle20");

    // Basic frame: low ten bits set, ctrl all ones.
    send_frame("basic", 20'h003FF, 16'h03FF, 5'b11111);
    idle(2);

    // Write frame: CE#/WE#/LB#/UB# low, OE# high.
    send_frame("write", 20'hABCDE, 16'h1234, 5'b00100);
    check("write.ce", 32'(chip_en), 32'd0);
    check("write.oe", 32'(out_en), 32'd1);
    idle(2);

    // Abort after 7 bits: previous frame must stay on the pins.
    drive_bits(20'h55555, 16'hAAAA, 5'b11011, 0, 7);
    idle(3);
    @(posedge clk);
    #1 check_outputs("abort.hold");
    send_frame("abort.next", 20'h12345, 16'hBEEF, 5'b01010);

    // Back-to-back with ctrl_en held high across both frames.
    send_frame("b2b.1", 20'h00001, 16'h0001, 5'b11110);
    send_frame("b2b.2", 20'hFFFFF, 16'hFFFF, 5'b10101);
    idle(2);

    // Reset in the middle of a frame.
    drive_bits(20'h0F0F0, 16'h5A5A, 5'b00000, 0, 12);
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_addr = 20'h00000;
    exp_data = 16'h0000;
    exp_strb = 5'b11111;
    check_outputs("midreset");
    ctrl_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    send_frame("after_reset", 20'hC0FFE, 16'h8001, 5'b01101);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
